demuxn_stream: RTL and testbench
================================

DEMUXN_STREAM -- requirements
Module: demuxn_stream

Interface
REQ-001 SHALL have parameter dwidth, default 8: data bitwidth per beat.
REQ-002 SHALL have parameter swidth, default 2: select bitwidth; channel count seln = 2**swidth.
REQ-003 SHALL have parameter depth, default 4: per-channel buffer depth; power of two, >= 2.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port d  input  dwidth: input beat data.
REQ-007 SHALL have port sel  input  swidth: destination channel of the input beat.
REQ-008 SHALL have port in_valid  input  1: input beat present.
REQ-009 SHALL have port in_ready  output  1: input beat accepted this cycle when high with in_valid.
REQ-010 SHALL have port outs  output  seln*dwidth: channel i data at bits [i*dwidth +: dwidth].
REQ-011 SHALL have port out_valid  output  seln: per-channel beat present.
REQ-012 SHALL have port out_ready  input  seln: per-channel consumer ready.
REQ-013 SHALL have port drop_cnt  output  16: dropped-beat count; present only when DEMUXN_STREAM_DROP_EN is defined.

Function
REQ-014 SHALL hold one independent FIFO of depth entries per channel, with count range 0..depth.
REQ-015 SHALL accept an input beat when in_valid && in_ready; the beat is written to FIFO[sel] at that edge.
REQ-016 SHALL give latency 1: an accepted beat into an empty channel appears on out_valid[sel] and its outs slice in the next cycle.
REQ-017 SHALL drive out_valid[i] = (count[i] != 0) and outs slice i = FIFO[i] head, all-zero when count[i] == 0.
REQ-018 SHALL pop channel i on out_valid[i] && out_ready[i]; pops on several channels in the same cycle are independent.
REQ-019 SHALL, on simultaneous push and pop on the same non-full channel, leave count unchanged and advance both pointers.
REQ-020 SHALL, without drop mode, drive in_ready = !full[sel], combinationally from sel and registered count; a full channel does not accept even with a same-cycle pop.
REQ-021 SHALL wrap read/write pointers modulo depth; there is no ordering across channels, and per-channel order is FIFO.
REQ-022 SHALL leave FIFO contents and outs unaffected by out_ready on an empty channel (no underflow; count never below 0).
REQ-023 SHALL keep out_valid/outs stable while out_valid[i] && !out_ready[i] (AXI-style hold).

Reset
REQ-024 SHALL, while rst is high at an edge, clear all counts, pointers, out_valid (0), outs (all zero) and drop_cnt (0); in-flight and buffered beats are discarded.
REQ-025 SHALL ignore in_valid and out_ready on the reset edge; in_ready SHALL read 1 from the first cycle after reset.

Configuration
REQ-026 SHALL, with DEMUXN_STREAM_DROP_EN defined, drive in_ready constantly 1; a beat targeting a full channel is discarded and drop_cnt increments by 1, saturating at 16'hFFFF.
REQ-027 SHALL, with DEMUXN_STREAM_DROP_EN undefined, apply backpressure per REQ-020 and omit drop_cnt and its logic.

Structure
REQ-028 SHALL place the clog2 helper function and the DROP_CNT_MAX constant (16'hFFFF) in shared package demuxn_stream_pkg.
REQ-029 SHALL implement each channel buffer as one sub-module, demuxn_fifo (parameters dwidth, depth), instantiated seln times by a generate loop.

Verification
REQ-030 SHALL cover: reset, then d=8'hA5 sel=2 valid for one cycle -> next cycle out_valid=4'b0100, outs[23:16]=8'hA5, other slices 0.
REQ-031 SHALL cover: 4 beats 8'h01..8'h04 to sel=1 with out_ready=0 -> in_ready low when sel=1 on 5th cycle; releasing out_ready[1] yields 01,02,03,04 in order.
REQ-032 SHALL cover: channel 0 full, beat to sel=3 -> accepted (in_ready=1); per-channel independence holds.
REQ-033 SHALL cover: simultaneous push and pop on channel 2 at count=2 -> count stays 2; 10 cycles streaming with no stall -> 10 beats delivered in order.
REQ-034 SHALL cover: with DEMUXN_STREAM_DROP_EN, 6 beats to full channel 0 -> in_ready=1 throughout, drop_cnt=6, channel 0 contents unchanged.
REQ-035 SHALL cover: rst asserted with 3 beats buffered in channel 1 -> next cycle out_valid=0, outs=0, drop_cnt=0.

Source files
------------

// File: rtl/demuxn_stream_pkg.sv
// Shared constants and helpers for the demuxn_stream slice.
// Holds the drop-counter ceiling and the constant-foldable clog2 used for pointer sizing.
package demuxn_stream_pkg;

    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

    // Smallest r with 2**r >= value; 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/demuxn_fifo.sv
// Per-channel buffer: depth-entry FIFO with registered count and pointers.
// Latency 1 (write at the edge, head visible next cycle); the caller must not push while full.
// Backpressure: head and out_vld hold while out_vld && !pop_rdy; out_dat reads zero when empty.
module demuxn_fifo
    import demuxn_stream_pkg::*;
#(
    parameter int dwidth = 8,
    parameter int depth  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [dwidth-1:0] push_dat,
    input  logic              pop_rdy,
    output logic              out_vld,
    output logic [dwidth-1:0] out_dat,
    output logic              full
);

    localparam int aw = clog2(depth);
    localparam int cw = clog2(depth + 1);
    localparam logic [cw-1:0] CNT_FULL = cw'(depth);

    logic [dwidth-1:0] mem_q [depth];
    logic [dwidth-1:0] mem_d [depth];
    logic [aw-1:0]     wr_ptr_q, wr_ptr_d;
    logic [aw-1:0]     rd_ptr_q, rd_ptr_d;
    logic [cw-1:0]     cnt_q, cnt_d;
    logic              pop;

    assign out_vld = (cnt_q != '0);
    assign full    = (cnt_q == CNT_FULL);
    assign pop     = out_vld && pop_rdy;
    assign out_dat = out_vld ? mem_q[rd_ptr_q] : '0;

    // depth is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + aw'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + aw'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + cw'(1);
            2'b01:   cnt_d = cnt_q - cw'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: a zero count masks stale entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/demuxn_stream.sv
// Stream demux: routes each input beat to one of 2**swidth per-channel FIFOs chosen by sel.
// Latency 1 from accept to out_valid; in_ready = !full[sel], or constantly 1 with
// DEMUXN_STREAM_DROP_EN, where beats to a full channel are discarded and counted in drop_cnt.
module demuxn_stream
    import demuxn_stream_pkg::*;
#(
    parameter int dwidth = 8,
    parameter int swidth = 2,
    parameter int depth  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [dwidth-1:0]           d,
    input  logic [swidth-1:0]           sel,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [(2**swidth)*dwidth-1:0] outs,
    output logic [(2**swidth)-1:0]      out_valid,
    input  logic [(2**swidth)-1:0]      out_ready
`ifdef DEMUXN_STREAM_DROP_EN
    ,
    output logic [15:0]                 drop_cnt
`endif
);

    localparam int seln = 2 ** swidth;

    logic [seln-1:0] full_vec;
    logic [seln-1:0] push_vec;

    // A full channel never takes a beat, even when it pops in the same cycle.
    for (genvar g = 0; g < seln; g++) begin : g_ch
        assign push_vec[g] = in_valid && (sel == swidth'(g)) && !full_vec[g];

        demuxn_fifo #(
            .dwidth (dwidth),
            .depth  (depth)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push_vec[g]),
            .push_dat (d),
            .pop_rdy  (out_ready[g]),
            .out_vld  (out_valid[g]),
            .out_dat  (outs[g*dwidth +: dwidth]),
            .full     (full_vec[g])
        );
    end

`ifdef DEMUXN_STREAM_DROP_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign in_ready = 1'b1;
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (in_valid && full_vec[sel] && (drop_cnt_q != DROP_CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end
`else
    assign in_ready = !full_vec[sel];
`endif

endmodule

// File: tb/tb_demuxn_stream.sv
// Directed self-checking bench for demuxn_stream (default parameters, 4 channels x 4 deep).
// Covers the drop counter when DEMUXN_STREAM_DROP_EN is defined.
module tb_demuxn_stream;

`ifdef DEMUXN_STREAM_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  d;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] outs;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
`ifdef DEMUXN_STREAM_DROP_EN
    logic [15:0] drop_cnt;
`endif

    int n_chk;
    int n_bad;

    demuxn_stream #(
        .dwidth (8),
        .swidth (2),
        .depth  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d         (d),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .outs      (outs),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUXN_STREAM_DROP_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it, where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [1:0] s, input logic [7:0] v);
        sel      = s;
        d        = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        d         = '0;
        sel       = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_outs", 64'(outs), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);

        // Single beat to channel 2
        push_beat(2'd2, 8'hA5);
        chk("one_out_valid", 64'(out_valid), 64'h4);
        chk("one_outs", 64'(outs), 64'h00A5_0000);
        out_ready = 4'b0100;
        tick();
        out_ready = '0;
        chk("one_drained", 64'(out_valid), 64'h0);

        // Fill channel 1, then a fifth beat must see backpressure
        for (int i = 1; i <= 4; i++) begin
            sel = 2'd1;
            #1;
            chk("fill1_in_ready", 64'(in_ready), 64'h1);
            push_beat(2'd1, 8'(i));
        end
        sel      = 2'd1;
        d        = 8'h05;
        in_valid = 1'b1;
        #1;
        chk("full1_in_ready", 64'(in_ready), DROP_EN ? 64'h1 : 64'h0);
        tick();
        in_valid = 1'b0;
        chk("full1_out_valid", 64'(out_valid), 64'h2);
        chk("full1_head", 64'(outs[15:8]), 64'h01);
        tick();
        chk("hold_head", 64'(outs[15:8]), 64'h01);
        out_ready = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            chk("order1_vld", 64'(out_valid[1]), 64'h1);
            chk("order1_dat", 64'(outs[15:8]), 64'(k));
            tick();
        end
        out_ready = '0;
        chk("order1_empty", 64'(out_valid), 64'h0);

        // Channel 0 full does not block channel 3
        for (int i = 0; i < 4; i++) push_beat(2'd0, 8'h10 + 8'(i));
        sel = 2'd0;
        #1;
        chk("full0_in_ready", 64'(in_ready), DROP_EN ? 64'h1 : 64'h0);
        sel = 2'd3;
        #1;
        chk("indep_in_ready", 64'(in_ready), 64'h1);
        push_beat(2'd3, 8'h77);
        chk("indep_out_valid", 64'(out_valid), 64'h9);
        chk("indep_outs", 64'(outs), 64'h7700_0010);
        // Full channel with same-cycle pop still refuses the beat
        sel       = 2'd0;
        d         = 8'hEE;
        in_valid  = 1'b1;
        out_ready = 4'b0001;
        #1;
        chk("fullpop_in_ready", 64'(in_ready), DROP_EN ? 64'h1 : 64'h0);
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        chk("fullpop_head", 64'(outs[7:0]), 64'h11);
        for (int k = 0; k < 3; k++) begin
            chk("drain0_dat", 64'(outs[7:0]), 64'h11 + 64'(k));
            tick();
        end
        out_ready = '0;
        chk("drain_all_empty", 64'(out_valid), 64'h0);

        // Push and pop together on channel 2 at count 2
        push_beat(2'd2, 8'h20);
        push_beat(2'd2, 8'h21);
        out_ready = 4'b0100;
        push_beat(2'd2, 8'h22);
        out_ready = '0;
        chk("pp_head", 64'(outs[23:16]), 64'h21);
        out_ready = 4'b0100;
        tick();
        chk("pp_second", 64'(outs[23:16]), 64'h22);
        chk("pp_second_vld", 64'(out_valid), 64'h4);
        tick();
        out_ready = '0;
        chk("pp_empty", 64'(out_valid), 64'h0);

        // Ten beats streaming through channel 3 without a stall
        out_ready = 4'b1000;
        sel       = 2'd3;
        in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            d = 8'h30 + 8'(k);
            #1;
            chk("stream_in_ready", 64'(in_ready), 64'h1);
            tick();
            chk("stream_dat", 64'(outs[31:24]), 64'h30 + 64'(k));
        end
        in_valid = 1'b0;
        tick();
        out_ready = '0;
        chk("stream_empty", 64'(out_valid), 64'h0);

        // Reset with beats buffered, plus traffic on the reset edge
        for (int i = 0; i < 3; i++) push_beat(2'd1, 8'h60 + 8'(i));
        chk("prerst_vld", 64'(out_valid), 64'h2);
        rst       = 1'b1;
        sel       = 2'd1;
        d         = 8'h99;
        in_valid  = 1'b1;
        out_ready = 4'b1111;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = '0;
        #1;
        chk("rst2_out_valid", 64'(out_valid), 64'h0);
        chk("rst2_outs", 64'(outs), 64'h0);
        chk("rst2_in_ready", 64'(in_ready), 64'h1);
`ifdef DEMUXN_STREAM_DROP_EN
        chk("rst2_drop_cnt", 64'(drop_cnt), 64'h0);
`endif
        tick();
        chk("rst2_no_write", 64'(out_valid), 64'h0);

`ifdef DEMUXN_STREAM_DROP_EN
        // Six beats into a full channel 0 are discarded and counted
        for (int i = 0; i < 4; i++) push_beat(2'd0, 8'h40 + 8'(i));
        for (int k = 0; k < 6; k++) begin
            sel      = 2'd0;
            d        = 8'h50 + 8'(k);
            in_valid = 1'b1;
            #1;
            chk("drop_in_ready", 64'(in_ready), 64'h1);
            tick();
        end
        in_valid = 1'b0;
        chk("drop_cnt", 64'(drop_cnt), 64'h6);
        out_ready = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            chk("drop_keep", 64'(outs[7:0]), 64'h40 + 64'(k));
            tick();
        end
        out_ready = '0;
        chk("drop_empty", 64'(out_valid), 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
